// File: rtl/idct_unit_if.sv
// idct_unit_if: row-in / column-out stream bundle for idct_unit.
// slave is the transform's view; master is the producer/consumer view.
interface idct_unit_if #(
   parameter int IW = 12,
   parameter int OW = 9
);
   logic            i_valid;
   logic [4*IW-1:0] coef_in;
   logic            o_valid;
   logic            o_first;
   logic [4*OW-1:0] res_out;

   modport slave  (input  i_valid, coef_in, output o_valid, o_first, res_out);
   modport master (output i_valid, coef_in, input  o_valid, o_first, res_out);
endinterface

// File: rtl/idct_unit.sv
// idct_unit: streaming 4x4 inverse integer transform: row pass, ping-pong transpose, column pass.
// Optional macro IDCT_SAT_EN saturates column outputs to OW bits; otherwise they wrap.
module idct_unit #(
   parameter int IW = 12,
   parameter int OW = 9
) (
   input  logic       clk,
   input  logic       rstn,
   idct_unit_if.slave bus
);
   typedef logic signed [27:0] acc_t;
   typedef logic signed [15:0] mid_t;
   typedef enum logic {IDLE, RUN} state_t;

`ifdef IDCT_SAT_EN
   localparam acc_t OMAX = (28'sd1 <<< (OW - 1)) - 28'sd1;
   localparam acc_t OMIN = -(28'sd1 <<< (OW - 1));
`endif

   function automatic void bfly(input acc_t c0, input acc_t c1, input acc_t c2, input acc_t c3,
                                output acc_t y0, output acc_t y1, output acc_t y2, output acc_t y3);
      acc_t e0, e1, o0, o1;
      e0 = (c0 + c2) <<< 6;
      e1 = (c0 - c2) <<< 6;
      o0 = 28'sd83 * c1 + 28'sd36 * c3;
      o1 = 28'sd36 * c1 - 28'sd83 * c3;
      y0 = e0 + o0;
      y1 = e1 + o1;
      y2 = e1 - o1;
      y3 = e0 - o0;
   endfunction

   function automatic mid_t rnd_row(input acc_t y);
      return mid_t'((y + 28'sd64) >>> 7);
   endfunction

   function automatic logic signed [OW-1:0] rnd_col(input acc_t y);
      acc_t t;
      t = (y + 28'sd2048) >>> 12;
`ifdef IDCT_SAT_EN
      if (t > OMAX)
         t = OMAX;
      else if (t < OMIN)
         t = OMIN;
`endif
      return OW'(t);
   endfunction

   // Row pass: butterfly on the incoming row, result registered with its slot index
   acc_t rc [4];
   acc_t ry [4];
   mid_t row_d [4];
   mid_t row_q [4];
   logic       wvld_q;
   logic [1:0] wslot_q;
   logic [1:0] wr_row_q;

   always_comb begin
      for (int k = 0; k < 4; k++)
         rc[k] = acc_t'(signed'(bus.coef_in[IW*k +: IW]));
      bfly(rc[0], rc[1], rc[2], rc[3], ry[0], ry[1], ry[2], ry[3]);
      for (int k = 0; k < 4; k++)
         row_d[k] = rnd_row(ry[k]);
   end

   always_ff @(posedge clk) begin
      if (bus.i_valid)
         for (int k = 0; k < 4; k++)
            row_q[k] <= row_d[k];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wvld_q   <= 1'b0;
         wslot_q  <= 2'd0;
         wr_row_q <= 2'd0;
      end else begin
         wvld_q <= bus.i_valid;
         if (bus.i_valid) begin
            wslot_q  <= wr_row_q;
            wr_row_q <= wr_row_q + 2'd1;
         end
      end
   end

   // Transpose: two banks of 4x4 row-pass results
   mid_t       mem_q [2][4][4];
   logic       wr_bank_q;
   logic [1:0] full_q;
   logic       wr3;

   assign wr3 = wvld_q && (wslot_q == 2'd3);

   always_ff @(posedge clk) begin
      if (wvld_q)
         for (int k = 0; k < 4; k++)
            mem_q[wr_bank_q][wslot_q][k] <= row_q[k];
   end

   // Column-pass control
   state_t     state_q, state_d;
   logic [1:0] rd_col_q, rd_col_d;
   logic       rd_bank_q, rd_bank_d;
   logic       col_en, clr_full;

   always_comb begin
      state_d   = state_q;
      rd_col_d  = rd_col_q;
      rd_bank_d = rd_bank_q;
      col_en    = 1'b0;
      clr_full  = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr3) begin
               state_d   = RUN;
               rd_col_d  = 2'd0;
               rd_bank_d = wr_bank_q;
            end
         end
         RUN: begin
            col_en = 1'b1;
            if (rd_col_q == 2'd3) begin
               clr_full = 1'b1;
               // The other bank may complete on this very edge, so look at the write too
               if (full_q[~rd_bank_q] || (wr3 && (wr_bank_q != rd_bank_q))) begin
                  rd_bank_d = ~rd_bank_q;
                  rd_col_d  = 2'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               rd_col_d = rd_col_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         rd_col_q  <= 2'd0;
         rd_bank_q <= 1'b0;
         wr_bank_q <= 1'b0;
         full_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         rd_col_q  <= rd_col_d;
         rd_bank_q <= rd_bank_d;
         if (clr_full)
            full_q[rd_bank_q] <= 1'b0;
         if (wr3) begin
            full_q[wr_bank_q] <= 1'b1;
            wr_bank_q         <= ~wr_bank_q;
         end
      end
   end

   // Column pass: butterfly down the selected column, registered output
   acc_t cc [4];
   acc_t cy [4];
   logic [4*OW-1:0] res_d;
   logic [4*OW-1:0] res_q;
   logic            o_valid_q, o_first_q;

   always_comb begin
      res_d = '0;
      for (int n = 0; n < 4; n++)
         cc[n] = acc_t'(mem_q[rd_bank_q][n][rd_col_q]);
      bfly(cc[0], cc[1], cc[2], cc[3], cy[0], cy[1], cy[2], cy[3]);
      for (int i = 0; i < 4; i++)
         res_d[OW*i +: OW] = rnd_col(cy[i]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_valid_q <= 1'b0;
         o_first_q <= 1'b0;
         res_q     <= '0;
      end else begin
         o_valid_q <= col_en;
         o_first_q <= col_en && (rd_col_q == 2'd0);
         if (col_en)
            res_q <= res_d;
      end
   end

   assign bus.o_valid = o_valid_q;
   assign bus.o_first = o_first_q;
   assign bus.res_out = res_q;
endmodule

// File: tb/tb_idct_unit.sv
// tb_idct_unit: directed and randomized checks of idct_unit against an integer matrix model.
// A second instance with OW=8 exercises the wrap/saturate difference (IDCT_SAT_EN).
module tb_idct_unit;
   localparam int IW = 12;
   localparam int OW = 9;

   typedef struct {
      int              cyc;
      logic [4*OW-1:0] data;
      logic            first;
   } beat_t;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   int   cyc  = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   beat_t expq [$];
   beat_t mb;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   idct_unit_if #(.IW(IW), .OW(OW)) bus ();
   idct_unit_if #(.IW(IW), .OW(8))  bus8 ();

   idct_unit #(.IW(IW), .OW(OW)) dut  (.clk(clk), .rstn(rstn), .bus(bus));
   idct_unit #(.IW(IW), .OW(8))  dut8 (.clk(clk), .rstn(rstn), .bus(bus8));

   assign bus8.i_valid = bus.i_valid;
   assign bus8.coef_in = bus.coef_in;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Inverse basis: y[k] = sum_n mc(k,n) * c[n]
   function automatic int mc(input int k, input int n);
      case (k * 4 + n)
         0, 2, 4, 8, 12, 14: return 64;
         6, 10:              return -64;
         1, 11:              return 83;
         3, 5:               return 36;
         7, 13:              return -83;
         9, 15:              return -36;
         default:            return 0;
      endcase
   endfunction

   function automatic int rnd(input int y, input int sh);
      return (y + (1 <<< (sh - 1))) >>> sh;
   endfunction

   function automatic int reduce(input int v, input int w);
      int lim = 1 << (w - 1);
`ifdef IDCT_SAT_EN
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
`else
      int m = v & ((lim << 1) - 1);
      return (m >= lim) ? m - (lim << 1) : m;
`endif
   endfunction

   function automatic logic [4*OW-1:0] pack4(input int a, input int b, input int c, input int d);
      return {OW'(d), OW'(c), OW'(b), OW'(a)};
   endfunction

   task automatic push_block(input int blk [16], input int e3);
      int    t [4][4];
      int    s;
      beat_t b;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) begin
            s = 0;
            for (int n = 0; n < 4; n++) s += mc(k, n) * blk[r*4 + n];
            t[r][k] = rnd(s, 7);
         end
      for (int j = 0; j < 4; j++) begin
         b.data = '0;
         for (int i = 0; i < 4; i++) begin
            s = 0;
            for (int n = 0; n < 4; n++) s += mc(i, n) * t[n][j];
            b.data[OW*i +: OW] = OW'(reduce(rnd(s, 12), OW));
         end
         b.cyc   = e3 + 2 + j;
         b.first = (j == 0);
         expq.push_back(b);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.i_valid = 1'b0;
      end
   endtask

   task automatic drive_row(input int blk [16], input int r);
      @(negedge clk);
      bus.i_valid = 1'b1;
      for (int k = 0; k < 4; k++)
         bus.coef_in[IW*k +: IW] = IW'(blk[r*4 + k]);
   endtask

   // Returns at the negedge where row 3 is being driven (cyc = acceptance edge - 1)
   task automatic send_block(input int blk [16], input int gap0, input int gap);
      for (int r = 0; r < 4; r++) begin
         idle((r == 0) ? gap0 : gap);
         drive_row(blk, r);
         if (r == 3) push_block(blk, cyc + 1);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && bus.o_valid) begin
         check("beat expected", 64'(expq.size() != 0), 64'd1);
         if (expq.size() != 0) begin
            mb = expq.pop_front();
            check("beat cycle", 64'(mb.cyc), 64'(cyc));
            check("o_first", 64'(bus.o_first), 64'(mb.first));
            check("res_out", 64'(bus.res_out), 64'(mb.data));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   int dc [16], mx [16], ramp [16], alt [16], rb [16];
   logic [7:0] exp8;

   initial begin
      bus.i_valid = 1'b0;
      bus.coef_in = '0;
      for (int i = 0; i < 16; i++) begin
         dc[i]   = 0;
         mx[i]   = 2047;
         ramp[i] = i * 100 - 800;
         alt[i]  = (i % 2 == 0) ? 2047 : -2048;
      end
      dc[0] = 512;

      #1 rstn = 1'b0;
      repeat (2) @(negedge clk);
      check("reset o_valid", 64'(bus.o_valid), 64'd0);
      check("reset o_first", 64'(bus.o_first), 64'd0);
      check("reset res_out", 64'(bus.res_out), 64'd0);
      rstn = 1'b1;
      idle(2);

      // DC block: first beat 6 cycles after row 0, all samples 4
      send_block(dc, 0, 0);
      idle(2);
      check("dc early o_valid", 64'(bus.o_valid), 64'd0);
      idle(1);
      check("dc first o_valid", 64'(bus.o_valid), 64'd1);
      check("dc first o_first", 64'(bus.o_first), 64'd1);
      check("dc first data", 64'(bus.res_out), 64'(pack4(4, 4, 4, 4)));
      idle(1);
      check("dc beat1 o_first", 64'(bus.o_first), 64'd0);
      idle(4);

      // All-max block, including the OW=8 instance
      send_block(mx, 0, 0);
      idle(3);
      check("allmax col0", 64'(bus.res_out), 64'(pack4(238, -45, 45, 9)));
`ifdef IDCT_SAT_EN
      exp8 = 8'd127;
`else
      exp8 = 8'hEE;
`endif
      check("ow8 col0 lane0", 64'(bus8.res_out[7:0]), 64'(exp8));
      idle(1);
      check("allmax col1", 64'(bus.res_out), 64'(pack4(-45, 9, -9, -2)));
      idle(1);
      check("allmax col2", 64'(bus.res_out), 64'(pack4(45, -9, 9, 2)));
      idle(1);
      check("allmax col3", 64'(bus.res_out), 64'(pack4(9, -2, 2, 0)));
      idle(4);

      // Three blocks back-to-back, then one with 2-cycle row gaps
      send_block(ramp, 0, 0);
      send_block(alt, 0, 0);
      send_block(dc, 0, 0);
      send_block(mx, 0, 2);
      idle(10);

      // Reset during a partial block while a previous block is still emitting
      send_block(alt, 0, 0);
      for (int r = 0; r < 3; r++) drive_row(ramp, r);
      @(posedge clk);
      check("pre-reset o_valid", 64'(bus.o_valid), 64'd1);
      #2 rstn = 1'b0;
      bus.i_valid = 1'b0;
      #1;
      check("async reset o_valid", 64'(bus.o_valid), 64'd0);
      check("async reset res_out", 64'(bus.res_out), 64'd0);
      expq.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      idle(8);
      send_block(ramp, 0, 0);
      idle(10);

      // Random blocks with random gaps
      for (int b = 0; b < 1000; b++) begin
         for (int i = 0; i < 16; i++) rb[i] = int'($urandom_range(4095)) - 2048;
         send_block(rb, int'($urandom_range(2)), int'($urandom_range(2)));
      end
      idle(12);

      check("queue drained", 64'(expq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
